// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: condition codes and the
// redirect/squash state machine encoding.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    COND_NONE = 3'b000,
    COND_BEQZ = 3'b001,
    COND_BNEZ = 3'b010,
    COND_BLTZ = 3'b011,
    COND_BGEZ = 3'b100,
    COND_JMP  = 3'b101
  } cond_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational zero/sign decode of Rs against a condition code; the
// generalised form of the old Rs-vs-zero branch flag logic.
module branch_cond_eval #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [2:0]       cond,
  output logic             taken
);
  import branch_resolve_unit_pkg::*;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    taken = 1'b0;
    case (cond)
      COND_BEQZ: taken = (rs == '0);
      COND_BNEZ: taken = (rs != '0);
      COND_BLTZ: taken = rs[WIDTH-1];
      COND_BGEZ: taken = ~rs[WIDTH-1];
      COND_JMP:  taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX/MEM branch resolution: registered direction/target, mispredict flush
// with a squash window, and saturating taken/mispredict counters.
module branch_resolve_unit #(
  parameter int WIDTH      = 16,
  parameter int SQUASH_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [2:0]       in_cond,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [WIDTH-1:0] in_pc_plus2,
  input  logic [WIDTH-1:0] in_offset,
  input  logic             in_pred_taken,
  output logic             out_valid,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_target,
  output logic             flush,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             squashing,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  import branch_resolve_unit_pkg::*;

  localparam int SQ_W = (SQUASH_CYC < 2) ? 1 : $clog2(SQUASH_CYC + 1);

  state_e           state_q, state_d;
  logic [SQ_W-1:0]  sq_cnt_q, sq_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_taken_d;
  logic             flush_q, flush_d;
  logic [WIDTH-1:0] out_target_q, out_target_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             cond_taken;
  logic             accept;
  logic             mispredict;
  logic [WIDTH-1:0] target;

  branch_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
    .rs    (in_rs),
    .cond  (in_cond),
    .taken (cond_taken)
  );

  assign target     = in_pc_plus2 + in_offset;
  assign accept     = in_valid && !stall && (state_q == ST_RUN);
  assign mispredict = accept && (cond_taken != in_pred_taken);

  // Stall holds everything, including a pending flush pulse.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_taken_d   = out_taken_q;
    flush_d       = flush_q;
    out_target_d  = out_target_q;
    redirect_pc_d = redirect_pc_q;
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (!stall) begin
      out_valid_d = accept;
      out_taken_d = accept && cond_taken;
      flush_d     = mispredict;
      if (accept) out_target_d = target;
      if (mispredict) redirect_pc_d = cond_taken ? target : in_pc_plus2;
      if (accept && cond_taken && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + 1'b1;
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (mispredict) begin
            state_d  = ST_SQUASH;
            sq_cnt_d = SQ_W'(SQUASH_CYC);
          end
        end
        ST_SQUASH: begin
          if (sq_cnt_q == SQ_W'(1)) begin
            state_d  = ST_RUN;
            sq_cnt_d = '0;
          end else begin
            sq_cnt_d = sq_cnt_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      sq_cnt_q      <= '0;
      out_valid_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      flush_q       <= 1'b0;
      out_target_q  <= '0;
      redirect_pc_q <= '0;
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      sq_cnt_q      <= sq_cnt_d;
      out_valid_q   <= out_valid_d;
      out_taken_q   <= out_taken_d;
      flush_q       <= flush_d;
      out_target_q  <= out_target_d;
      redirect_pc_q <= redirect_pc_d;
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_taken   = out_taken_q;
  assign out_target  = out_target_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign squashing   = (state_q == ST_SQUASH);
  assign taken_cnt   = taken_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: dut_a (SQUASH_CYC=2) checked every cycle against a scoreboard
// model; dut_b (SQUASH_CYC=1, CNT_W=2) checked for counter saturation.
module tb_branch_resolve_unit;

  localparam int W  = 16;
  localparam int SQ = 2;

  logic         clk;
  logic         rst, stall, in_valid, in_pred_taken;
  logic [2:0]   in_cond;
  logic [W-1:0] in_rs, in_pc_plus2, in_offset;

  logic         a_out_valid, a_out_taken, a_flush, a_squashing;
  logic [W-1:0] a_out_target, a_redirect_pc;
  logic [15:0]  a_taken_cnt, a_mispred_cnt;

  logic         b_out_valid, b_out_taken, b_flush, b_squashing;
  logic [W-1:0] b_out_target, b_redirect_pc;
  logic [1:0]   b_taken_cnt, b_mispred_cnt;

  branch_resolve_unit #(.WIDTH(W), .SQUASH_CYC(SQ), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_cond(in_cond),
    .in_rs(in_rs), .in_pc_plus2(in_pc_plus2), .in_offset(in_offset),
    .in_pred_taken(in_pred_taken), .out_valid(a_out_valid), .out_taken(a_out_taken),
    .out_target(a_out_target), .flush(a_flush), .redirect_pc(a_redirect_pc),
    .squashing(a_squashing), .taken_cnt(a_taken_cnt), .mispred_cnt(a_mispred_cnt)
  );

  branch_resolve_unit #(.WIDTH(W), .SQUASH_CYC(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_cond(in_cond),
    .in_rs(in_rs), .in_pc_plus2(in_pc_plus2), .in_offset(in_offset),
    .in_pred_taken(in_pred_taken), .out_valid(b_out_valid), .out_taken(b_out_taken),
    .out_target(b_out_target), .flush(b_flush), .redirect_pc(b_redirect_pc),
    .squashing(b_squashing), .taken_cnt(b_taken_cnt), .mispred_cnt(b_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         valid;
    logic         taken;
    logic [W-1:0] target;
    logic         flush;
    logic [W-1:0] redirect;
    logic         squashing;
    logic [15:0]  taken_cnt;
    logic [15:0]  mis_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  logic m_sq;
  int   m_cnt;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] c, input logic [W-1:0] rs);
    case (c)
      3'b001:  return rs == 16'h0000;
      3'b010:  return rs != 16'h0000;
      3'b011:  return rs[W-1];
      3'b100:  return !rs[W-1];
      3'b101:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic s, input logic v, input logic [2:0] c,
                            input logic [W-1:0] rs, input logic [W-1:0] pc2,
                            input logic [W-1:0] off, input logic pred);
    logic t, acc, mis;
    logic [W-1:0] tgt;
    if (r) begin
      m     = '0;
      m_sq  = 1'b0;
      m_cnt = 0;
    end else if (!s) begin
      acc = v && !m_sq;
      t   = ref_taken(c, rs);
      tgt = pc2 + off;
      mis = acc && (t != pred);
      m.valid = acc;
      m.taken = acc && t;
      m.flush = mis;
      if (acc) m.target = tgt;
      if (mis) m.redirect = t ? tgt : pc2;
      if (acc && t && m.taken_cnt != 16'hFFFF) m.taken_cnt = m.taken_cnt + 16'd1;
      if (mis && m.mis_cnt != 16'hFFFF) m.mis_cnt = m.mis_cnt + 16'd1;
      if (m_sq) begin
        if (m_cnt == 1) begin
          m_sq  = 1'b0;
          m_cnt = 0;
        end else m_cnt--;
      end else if (mis) begin
        m_sq  = 1'b1;
        m_cnt = SQ;
      end
      m.squashing = m_sq;
    end
    exp_q.push_back(m);
  endtask

  task automatic cycle(input string lbl, input logic r, input logic s, input logic v,
                       input logic [2:0] c, input logic [W-1:0] rs, input logic [W-1:0] pc2,
                       input logic [W-1:0] off, input logic pred);
    exp_t e;
    rst = r; stall = s; in_valid = v; in_cond = c;
    in_rs = rs; in_pc_plus2 = pc2; in_offset = off; in_pred_taken = pred;
    model_step(r, s, v, c, rs, pc2, off, pred);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({lbl, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({lbl, ".valid"},     a_out_valid,   e.valid);
      check({lbl, ".taken"},     a_out_taken,   e.taken);
      check({lbl, ".target"},    a_out_target,  e.target);
      check({lbl, ".flush"},     a_flush,       e.flush);
      check({lbl, ".redirect"},  a_redirect_pc, e.redirect);
      check({lbl, ".squashing"}, a_squashing,   e.squashing);
      check({lbl, ".taken_cnt"}, a_taken_cnt,   e.taken_cnt);
      check({lbl, ".mis_cnt"},   a_mispred_cnt, e.mis_cnt);
    end
  endtask

  initial begin
    m = '0; m_sq = 1'b0; m_cnt = 0;
    cycle("rst0", 1, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0, 0);
    cycle("rst1", 1, 0, 1, 3'b101, 16'h0, 16'h1234, 16'h1, 0);
    check("reset.valid", a_out_valid, 0);
    check("reset.target", a_out_target, 16'h0000);

    // BEQZ taken, predicted not-taken: flush and enter squash
    cycle("beqz", 0, 0, 1, 3'b001, 16'h0000, 16'h0010, 16'h0006, 0);
    check("beqz.target_c", a_out_target, 16'h0016);
    check("beqz.redirect_c", a_redirect_pc, 16'h0016);
    check("beqz.squash_c", a_squashing, 1);

    // Two-cycle squash window drops back-to-back inputs
    cycle("drop0", 0, 0, 1, 3'b101, 16'h0, 16'h0100, 16'h0002, 1);
    check("drop0.valid_c", a_out_valid, 0);
    cycle("drop1", 0, 0, 1, 3'b101, 16'h0, 16'h0200, 16'h0002, 1);
    check("drop1.valid_c", a_out_valid, 0);
    cycle("acc3", 0, 0, 1, 3'b101, 16'h0, 16'h0300, 16'h0002, 1);
    check("acc3.target_c", a_out_target, 16'h0302);

    // Correctly predicted sign branches
    cycle("bltz", 0, 0, 1, 3'b011, 16'h8000, 16'h0020, 16'h0004, 1);
    cycle("bgez", 0, 0, 1, 3'b100, 16'h7FFF, 16'h0030, 16'h0004, 1);
    check("bgez.taken_cnt_c", a_taken_cnt, 16'd4);
    check("bgez.flush_c", a_flush, 0);

    // Target wrap and reserved code mispredict
    cycle("jmp_wrap", 0, 0, 1, 3'b101, 16'h0, 16'hFFFE, 16'h0004, 1);
    check("jmp_wrap.target_c", a_out_target, 16'h0002);
    cycle("rsvd", 0, 0, 1, 3'b111, 16'h0, 16'h0040, 16'h0010, 1);
    check("rsvd.redirect_c", a_redirect_pc, 16'h0040);
    check("rsvd.taken_c", a_out_taken, 0);

    // Stall inside the squash window extends it; flush holds under stall
    cycle("sq_st0", 0, 1, 1, 3'b101, 16'h0, 16'h0500, 16'h0002, 1);
    cycle("sq_st1", 0, 1, 1, 3'b101, 16'h0, 16'h0500, 16'h0002, 1);
    check("sq_st1.flush_c", a_flush, 1);
    cycle("sq_d0", 0, 0, 1, 3'b101, 16'h0, 16'h0500, 16'h0002, 1);
    check("sq_d0.squash_c", a_squashing, 1);
    cycle("sq_d1", 0, 0, 1, 3'b101, 16'h0, 16'h0500, 16'h0002, 1);
    check("sq_d1.squash_c", a_squashing, 0);
    cycle("bnez", 0, 0, 1, 3'b010, 16'h0005, 16'h0050, 16'h0010, 1);

    // Stall with a valid input holds everything, then resolves on release
    for (int i = 0; i < 3; i++)
      cycle("stall", 0, 1, 1, 3'b001, 16'h0000, 16'h0070, 16'h0008, 1);
    check("stall.target_c", a_out_target, 16'h0060);
    cycle("release", 0, 0, 1, 3'b001, 16'h0000, 16'h0070, 16'h0008, 1);
    check("release.target_c", a_out_target, 16'h0078);
    cycle("idle", 0, 0, 0, 3'b101, 16'h0, 16'h0999, 16'h0001, 0);
    check("idle.target_c", a_out_target, 16'h0078);

    // Reset while squashing and stalled
    cycle("mis2", 0, 0, 1, 3'b010, 16'h0000, 16'h0090, 16'h0010, 1);
    check("mis2.redirect_c", a_redirect_pc, 16'h0090);
    cycle("rst_sq", 1, 1, 1, 3'b101, 16'h0, 16'h0090, 16'h0010, 1);
    check("rst_sq.squash_c", a_squashing, 0);
    check("rst_sq.mis_c", a_mispred_cnt, 16'd0);
    cycle("post_rst", 0, 0, 1, 3'b101, 16'h0, 16'h00A0, 16'h0002, 1);
    check("post_rst.valid_c", a_out_valid, 1);

    // Saturation on the narrow-counter instance
    for (int i = 0; i < 5; i++)
      cycle("jmp_sat", 0, 0, 1, 3'b101, 16'h0, 16'h00C0, 16'h0002, 1);
    check("sat.a_taken_cnt", a_taken_cnt, 16'd6);
    check("sat.b_taken_cnt", b_taken_cnt, 2'd3);
    check("sat.b_mispred_cnt", b_mispred_cnt, 2'd0);
    check("sat.b_valid", b_out_valid, 1);
    check("sat.b_taken", b_out_taken, 1);
    check("sat.b_target", b_out_target, 16'h00C2);
    check("sat.b_flush", b_flush, 0);
    check("sat.b_redirect", b_redirect_pc, 16'h0000);
    check("sat.b_squashing", b_squashing, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
